// File: rtl/strobe_stretch.sv
// Stretches single-cycle strobes into visible pulses with a fixed low gap.
// Strobes arriving during a pulse are queued in a saturating counter.
module strobe_stretch #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int ON_MS    = 50,
    parameter int GAP_MS   = 50,
    parameter int PEND_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    output logic              signal,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int TICK_DIV = CLK_FREQ / 1000;
    localparam int MS_MAX   = (ON_MS > GAP_MS) ? ON_MS : GAP_MS;
    localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int MW       = (MS_MAX > 2) ? $clog2(MS_MAX) : 1;

    localparam logic [PW-1:0]     PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0]     ON_LAST  = MW'(ON_MS - 1);
    localparam logic [MW-1:0]     GAP_LAST = MW'(GAP_MS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    if (TICK_DIV < 2) begin : g_bad_tick
        $error("strobe_stretch: TICK_DIV must be >= 2");
    end
    if (ON_MS < 1) begin : g_bad_on
        $error("strobe_stretch: ON_MS must be >= 1");
    end
    if (GAP_MS < 1) begin : g_bad_gap
        $error("strobe_stretch: GAP_MS must be >= 1");
    end
    if (PEND_W < 1) begin : g_bad_pend
        $error("strobe_stretch: PEND_W must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        ON,
        GAP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [PW-1:0]     presc;
    logic [MW-1:0]     ms;
    logic [PEND_W-1:0] pend_nx;
    logic              ovf_nx;
    logic              enq;
    logic              tick;
    logic              on_done;
    logic              gap_done;

    assign tick     = (presc == PRE_LAST);
    assign on_done  = tick && (ms == ON_LAST);
    assign gap_done = tick && (ms == GAP_LAST);

    always_comb begin
        state_nx = state;
        pend_nx  = pending;
        ovf_nx   = 1'b0;
        enq      = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_nx = ON;
                    if (!strobe) pend_nx = pending - 1'b1;
                end else if (strobe) begin
                    state_nx = ON;
                end
            end
            ON: begin
                enq = strobe;
                if (on_done) state_nx = GAP;
            end
            GAP: begin
                // A dequeue coinciding with a strobe nets to zero.
                if (gap_done && pending != '0) begin
                    state_nx = ON;
                    if (!strobe) pend_nx = pending - 1'b1;
                end else begin
                    enq = strobe;
                    if (gap_done) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (enq) begin
            if (pending == PEND_MAX) ovf_nx = 1'b1;
            else pend_nx = pending + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            overflow <= 1'b0;
            signal   <= 1'b0;
            busy     <= 1'b0;
            presc    <= '0;
            ms       <= '0;
        end else begin
            state    <= state_nx;
            pending  <= pend_nx;
            overflow <= ovf_nx;
            signal   <= (state_nx == ON);
            busy     <= (state_nx != IDLE);
            // Timebase restarts on every state entry.
            if (state_nx != state || state == IDLE) begin
                presc <= '0;
                ms    <= '0;
            end else if (tick) begin
                presc <= '0;
                ms    <= ms + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule
